// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction-fetch initiator with return-address stack
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_pc     one-cycle pulse loading the first PC and clearing stack/flags
//   fetch_req, next_sel request next fetch; next-PC source (seq/branch/jump/pop)
//   target, push_ret    branch/jump address; push PC+1 on a jump (call)
//   imem_addr/imem_data word address out, instruction word in
//   ir, ir_valid, pc    latched instruction, handshake valid, its address
//   halted, stack_ovf, stack_unf   stop-bit halt and sticky stack error flags
module instr_fetch_unit #(
    parameter int FETCH_WAIT  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] start_pc,
    input  logic        fetch_req,
    input  logic [1:0]  next_sel,
    input  logic [31:0] target,
    input  logic        push_ret,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic        stack_ovf,
    output logic        stack_unf
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int SW = AW + 1;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;
    state_t state, state_nx;
    logic [31:0] cnt;
    logic [SW-1:0] sp;
    logic [SW-1:0] sp_dec;
    logic [31:0] stack [STACK_DEPTH];
    logic [31:0] pc_inc;
    logic [31:0] pc_nx;
    logic take;
    logic push;
    logic full;
    logic fetch_done;
    assign imem_addr  = pc;
    assign pc_inc     = pc + 32'd1;
    assign sp_dec     = sp - SW'(1);
    assign full       = sp == SW'(STACK_DEPTH);
    assign fetch_done = cnt == 32'(FETCH_WAIT);
    // take: the control unit accepted a non-stop instruction, so the PC advances
    assign take = state == HOLD && fetch_req && !ir[0];
    assign push = take && next_sel == 2'b10 && push_ret;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = start ? FETCH :
                   state == FETCH ? (fetch_done ? HOLD : FETCH) :
                   (state == HOLD && fetch_req) ? (ir[0] ? HALTED : FETCH) : state;
    end
    always_comb begin
        ir_valid = state == HOLD;
        halted   = state == HALTED;
    end
    // popping an empty stack falls back to the sequential address
    always_comb begin
        pc_nx = next_sel == 2'b00 ? pc_inc :
                next_sel != 2'b11 ? target :
                sp == '0 ? pc_inc : stack[sp_dec[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            ir        <= '0;
            cnt       <= '0;
            sp        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (start) begin
            pc        <= start_pc;
            cnt       <= '0;
            sp        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (state == FETCH) begin
                cnt <= cnt + 32'd1;
                if (fetch_done) ir <= imem_data;
            end
            if (take) begin
                pc  <= pc_nx;
                cnt <= '0;
                if (next_sel == 2'b11) begin
                    if (sp == '0) stack_unf <= 1'b1;
                    else sp <= sp_dec;
                end
                if (push) begin
                    if (full) stack_ovf <= 1'b1;
                    else sp <= sp + SW'(1);
                end
            end
        end
    end
    // stack storage has no reset; sp defines which entries are meaningful
    always_ff @(posedge clk) begin
        if (rst_n && !start && push && !full) stack[sp[AW-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, branch, call/return, stack flags, halt and reset
module tb_instr_fetch_unit;
    logic clk = 0;
    logic rst_n = 1, rst2_n = 1;
    logic start = 0, start2 = 0;
    logic [31:0] start_pc = 0;
    logic fetch_req = 0;
    logic [1:0] next_sel = 0;
    logic [31:0] target = 0;
    logic push_ret = 0;
    logic [31:0] imem_addr, imem_data, ir, pc;
    logic ir_valid, halted, stack_ovf, stack_unf;
    logic [31:0] imem_addr2, imem_data2, ir2, pc2;
    logic ir_valid2, halted2, stack_ovf2, stack_unf2;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    // memory image: word 0 and 0x77 are special, all others are addr*2 (stop bit clear)
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h08CA0052 : a == 32'h77 ? 32'h1 : {a[30:0], 1'b0};
    endfunction
    assign imem_data  = mem(imem_addr);
    assign imem_data2 = mem(imem_addr2);

    instr_fetch_unit #(.FETCH_WAIT(0), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .fetch_req(fetch_req), .next_sel(next_sel), .target(target), .push_ret(push_ret),
        .imem_addr(imem_addr), .imem_data(imem_data), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .halted(halted), .stack_ovf(stack_ovf), .stack_unf(stack_unf));

    instr_fetch_unit #(.FETCH_WAIT(2), .STACK_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .start_pc(start_pc),
        .fetch_req(fetch_req), .next_sel(next_sel), .target(target), .push_ret(push_ret),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .ir(ir2), .ir_valid(ir_valid2),
        .pc(pc2), .halted(halted2), .stack_ovf(stack_ovf2), .stack_unf(stack_unf2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one fetch_req in HOLD, then one cycle of FETCH (FETCH_WAIT=0) back into HOLD
    task automatic req(input logic [1:0] sel, input logic [31:0] tgt, input logic psh);
        fetch_req = 1; next_sel = sel; target = tgt; push_ret = psh;
        step();
        fetch_req = 0; push_ret = 0;
        step();
    endtask

    task automatic pulse_start(input logic [31:0] a);
        start = 1; start_pc = a;
        step();
        start = 0;
        step();
    endtask

    initial begin
        rst2_n = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_flags", {ir_valid, halted, stack_ovf, stack_unf}, 0);
        step();
        rst_n = 1;
        step();
        start = 1; start_pc = 0;
        step();
        start = 0;
        chk("start_addr", imem_addr, 0);
        chk("start_valid", ir_valid, 0);
        step();
        chk("first_ir", ir, 32'h08CA0052);
        chk("first_valid", ir_valid, 1);
        chk("first_pc", pc, 0);
        fetch_req = 1; next_sel = 2'b00;
        step();
        fetch_req = 0;
        chk("seq_pc", pc, 1);
        chk("seq_valid_drop", ir_valid, 0);
        step();
        chk("seq_valid_back", ir_valid, 1);
        chk("seq_ir", ir, 32'h2);
        req(2'b00, 0, 0);
        req(2'b00, 0, 0);
        chk("pc3", pc, 3);
        fetch_req = 1; next_sel = 2'b01; target = 32'h20;
        step();
        fetch_req = 0;
        chk("br_addr", imem_addr, 32'h20);
        step();
        chk("br_ir", ir, 32'h40);
        req(2'b01, 32'h5, 0);
        req(2'b10, 32'h40, 1);
        chk("call_pc", pc, 32'h40);
        req(2'b11, 0, 0);
        chk("ret_pc", pc, 6);
        chk("ret_unf", stack_unf, 0);
        req(2'b11, 0, 0);
        chk("unf_flag", stack_unf, 1);
        chk("unf_pc", pc, 7);
        req(2'b00, 0, 0);
        chk("unf_sticky", stack_unf, 1);
        pulse_start(32'h7);
        chk("start_clr_unf", stack_unf, 0);
        chk("restart_pc", pc, 7);
        req(2'b10, 32'h100, 1);
        req(2'b10, 32'h200, 1);
        req(2'b10, 32'h300, 1);
        req(2'b10, 32'h400, 1);
        chk("ovf_not_yet", stack_ovf, 0);
        req(2'b10, 32'h500, 1);
        chk("ovf_flag", stack_ovf, 1);
        chk("ovf_pc", pc, 32'h500);
        req(2'b11, 0, 0);
        chk("pop1", pc, 32'h301);
        req(2'b11, 0, 0);
        chk("pop2", pc, 32'h201);
        req(2'b11, 0, 0);
        chk("pop3", pc, 32'h101);
        req(2'b11, 0, 0);
        chk("pop4", pc, 32'h8);
        chk("pop4_unf", stack_unf, 0);
        req(2'b11, 0, 0);
        chk("pop5_unf", stack_unf, 1);
        chk("pop5_pc", pc, 32'h9);
        req(2'b01, 32'hFFFFFFFF, 1);
        chk("br_push_ignored_ovf", stack_ovf, 1);
        req(2'b00, 0, 0);
        chk("wrap_pc", pc, 0);
        chk("wrap_ir", ir, 32'h08CA0052);
        req(2'b01, 32'h77, 0);
        chk("stop_ir", ir, 1);
        fetch_req = 1; next_sel = 2'b00;
        step();
        fetch_req = 0;
        chk("halt_flag", halted, 1);
        chk("halt_valid", ir_valid, 0);
        chk("halt_pc", pc, 32'h77);
        req(2'b01, 32'h30, 0);
        chk("halt_stays", halted, 1);
        chk("halt_pc_held", pc, 32'h77);
        pulse_start(32'h10);
        chk("resume_halted", halted, 0);
        chk("resume_ir", ir, 32'h20);
        chk("resume_valid", ir_valid, 1);
        chk("resume_flags", {stack_ovf, stack_unf}, 0);
        rst2_n = 1;
        step();
        start2 = 1; start_pc = 32'h10;
        step();
        start2 = 0;
        fetch_req = 1; next_sel = 2'b01; target = 32'h99;
        step();
        chk("w2_c1_valid", ir_valid2, 0);
        step();
        fetch_req = 0;
        chk("w2_c2_valid", ir_valid2, 0);
        chk("w2_req_ignored", pc2, 32'h10);
        step();
        chk("w2_c3_valid", ir_valid2, 1);
        chk("w2_ir", ir2, 32'h20);
        fetch_req = 1; next_sel = 2'b00;
        step();
        fetch_req = 0;
        chk("w2_seq_pc", pc2, 32'h11);
        step();
        rst2_n = 0;
        #1;
        chk("w2_rst_pc", pc2, 0);
        chk("w2_rst_ir", ir2, 0);
        chk("w2_rst_addr", imem_addr2, 0);
        chk("w2_rst_flags", {ir_valid2, halted2, stack_ovf2, stack_unf2}, 0);
        step();
        rst2_n = 1;
        step();
        step();
        step();
        step();
        chk("w2_idle_valid", ir_valid2, 0);
        chk("w2_idle_ir", ir2, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface for the multi-cycle RISC core.
- Owns the PC and drives the word address to instruction memory, which returns the 32-bit word combinationally. Latches the word into IR and hands it to the control unit with a valid/request handshake.
- Computes the next PC: sequential, branch, jump/call or return. Maintains a small return-address stack and halts on an instruction whose stop bit is set.

Parameters:
- FETCH_WAIT, 0, extra cycles to wait after presenting the address before latching imem_data (0 = combinational memory).
- STACK_DEPTH, 4, number of return-address stack entries (power of 2, at least 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: load start_pc, clear the stack and flags, begin fetching.
- start_pc  input  32  word address of the first instruction.
- fetch_req  input  1  control unit finished the current IR and requests the next fetch.
- next_sel  input  2  next-PC source: 00 = PC+1, 01 = target (branch), 10 = target (jump/call), 11 = pop return stack.
- target  input  32  branch/jump word address, sampled with fetch_req.
- push_ret  input  1  with next_sel=10, push PC+1 (call).
- imem_addr  output  32  word address to instruction memory.
- imem_data  input  32  instruction word from memory.
- ir  output  32  latched instruction.
- ir_valid  output  1  ir holds a fresh instruction awaiting fetch_req.
- pc  output  32  address of the instruction in ir / being fetched.
- halted  output  1  stop-bit instruction retired; fetching stopped.
- stack_ovf  output  1  sticky: push attempted with the stack full.
- stack_unf  output  1  sticky: pop attempted with the stack empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; pc, ir and imem_addr = 0.
  - ir_valid, halted, stack_ovf and stack_unf = 0.
  - sp=0; stack contents are don't-care.
- imem_addr is driven from pc at all times.
- start has priority over everything in every state:
  - next edge: pc<=start_pc, sp<=0, flags cleared, ir_valid<=0, halted<=0, wait counter<=0, state<=FETCH.
- IDLE: waits for start; fetch_req is ignored.
- FETCH:
  - Counter increments each cycle.
  - On the edge where counter==FETCH_WAIT: ir<=imem_data, ir_valid<=1, state<=HOLD.
  - Latency from entering FETCH to ir_valid is FETCH_WAIT+1 cycles.
- HOLD: ir_valid=1 and ir stable until fetch_req=1. On that edge:
  - ir_valid<=0.
  - If ir[0] (stop bit)=1: state<=HALTED, halted<=1, pc unchanged, stack unchanged.
  - Else pc<=next PC, counter<=0, state<=FETCH:
    - 00: pc+1.
    - 01 or 10: target.
    - 11: stack[sp-1], sp<=sp-1. If sp==0: stack_unf<=1, pc<=pc+1.
  - Push happens when next_sel=10 and push_ret=1: stack[sp]<=pc+1, sp<=sp+1. If sp==STACK_DEPTH: no write, stack_ovf<=1; the jump is still taken.
  - push_ret with any other next_sel is ignored.
- fetch_req outside HOLD is ignored; there is no queued request.
- HALTED: halted=1, ir_valid=0; leaves only on start.
- Arithmetic: PC+1 is 32-bit modulo 2^32, so 0xFFFFFFFF+1 = 0. Stack pointer range is 0..STACK_DEPTH.
- Reset asserted mid-fetch or mid-hold aborts immediately; no partial IR update.
- Sticky flags clear only on reset or start.

Test Plan:
- Reset then start with start_pc=0, memory word 0 = 0x08CA0052, FETCH_WAIT=0 -> imem_addr=0; one cycle later ir=0x08CA0052, ir_valid=1, pc=0. fetch_req with next_sel=00 -> pc=1, ir_valid drops for exactly one cycle.
- Branch: in HOLD at pc=3, fetch_req, next_sel=01, target=0x20 -> imem_addr=0x20 next cycle, ir=mem[0x20].
- Call/return: at pc=5, next_sel=10, push_ret=1, target=0x40 -> pc=0x40, sp=1. Later next_sel=11 -> pc=6, sp=0. A second pop -> stack_unf=1, pc=prev+1.
- Overflow: 5 consecutive calls with STACK_DEPTH=4 -> stack_ovf=1 after the 5th, pc=5th target, sp=4.
- Stop bit: ir=0x00000001 in HOLD, fetch_req -> halted=1, ir_valid=0, pc held. Further fetch_req has no effect. A start pulse with start_pc=0x10 resumes: halted=0, ir=mem[0x10].
- FETCH_WAIT=2: ir_valid rises 3 cycles after entering FETCH. Asserting rst_n=0 in cycle 2 -> all outputs 0 immediately, state IDLE.
